// File: rtl/nx_roreg_indirect_access_mt.sv
// Indirect CSR read access to N_TABLES read-only arrays with wide entries.
// Optional read-to-clear pulse enabled by defining NX_ROREG_CLR_ON_READ_EN.
module nx_roreg_indirect_access_mt #(
    parameter int N_REG_ADDR_BITS = 11,
    parameter logic [N_REG_ADDR_BITS-1:0] STAT_ADDRESS = 11'h400,
    parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS = 11'h40C,
    parameter logic [N_REG_ADDR_BITS-1:0] DATA_ADDRESS = 11'h410,
    parameter int N_DATA_BITS = 96,
    parameter int N_ENTRIES   = 32,
    parameter int N_TABLES    = 4,
    localparam int NW = (N_DATA_BITS + 31) / 32,
    localparam int AW = $clog2(N_ENTRIES),
    localparam int TW = (N_TABLES > 1) ? $clog2(N_TABLES) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wr_stb,
    input  logic [N_REG_ADDR_BITS-1:0]               addr,
    input  logic [3:0]                               cmnd_op,
    input  logic [AW-1:0]                            cmnd_addr,
    input  logic [TW-1:0]                            cmnd_table_id,
    input  logic [N_TABLES*N_ENTRIES*N_DATA_BITS-1:0] mem_a,
    output logic [31:0]                              rd_dat,
    output logic [2:0]                               stat_code,
    output logic [4:0]                               stat_datawords,
    output logic [AW-1:0]                            stat_addr,
    output logic [TW-1:0]                            stat_table_id,
    output logic [15:0]                              capability_lst,
    output logic [3:0]                               capability_type,
    output logic                                     clr_vld,
    output logic [TW-1:0]                            clr_table,
    output logic [AW-1:0]                            clr_addr
);

    typedef enum logic {ST_IDLE, ST_CAPTURE} state_t;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_READ      = 4'd1;
    localparam logic [2:0] SC_OK        = 3'd0;
    localparam logic [2:0] SC_BUSY      = 3'd1;
    localparam logic [2:0] SC_BAD_OP    = 3'd3;
    localparam logic [2:0] SC_BAD_ADDR  = 3'd4;
    localparam logic [2:0] SC_BAD_TABLE = 3'd5;
    localparam int HW = NW * 32;
    localparam int NE = N_TABLES * N_ENTRIES;
    localparam int IW = $clog2(NE);

    state_t                  state_q;
    logic [2:0]              stat_code_q;
    logic [AW-1:0]           stat_addr_q;
    logic [TW-1:0]           stat_table_id_q;
    logic [HW-1:0]           hold_q;
    logic [31:0]             rd_dat_q;
    logic [31:0]             rd_dat_d;

    logic [N_DATA_BITS-1:0]  entry_w [NE];
    logic [31:0]             hold_word_w [NW];
    logic [IW-1:0]           sel_idx_w;
    logic                    cmd_wr_w;
    logic                    tbl_bad_w;
    logic                    addr_bad_w;

    genvar gi;
    generate
        for (gi = 0; gi < NE; gi++) begin : g_entry
            assign entry_w[gi] = mem_a[gi*N_DATA_BITS +: N_DATA_BITS];
        end
        for (gi = 0; gi < NW; gi++) begin : g_word
            assign hold_word_w[gi] = hold_q[gi*32 +: 32];
        end
    endgenerate

    assign cmd_wr_w   = wr_stb && (addr == CMND_ADDRESS);
    // Compare in 32 bits so non-power-of-2 sizes are checked by value.
    assign tbl_bad_w  = 32'(cmnd_table_id) >= 32'(N_TABLES);
    assign addr_bad_w = 32'(cmnd_addr) >= 32'(N_ENTRIES);
    assign sel_idx_w  = IW'(32'(stat_table_id_q) * 32'(N_ENTRIES) + 32'(stat_addr_q));

    always_comb begin
        rd_dat_d = '0;
        if (addr == STAT_ADDRESS) begin
            rd_dat_d = {stat_code_q, 5'(NW), 4'(stat_table_id_q), 4'b0, 16'(stat_addr_q)};
        end
        for (int k = 0; k < NW; k++) begin
            if (addr == DATA_ADDRESS + N_REG_ADDR_BITS'(k)) begin
                rd_dat_d = hold_word_w[k];
            end
        end
    end

`ifdef NX_ROREG_CLR_ON_READ_EN
    logic          clr_vld_q;
    logic [TW-1:0] clr_table_q;
    logic [AW-1:0] clr_addr_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            stat_code_q     <= SC_OK;
            stat_addr_q     <= '0;
            stat_table_id_q <= '0;
            hold_q          <= '0;
            rd_dat_q        <= '0;
`ifdef NX_ROREG_CLR_ON_READ_EN
            clr_vld_q       <= 1'b0;
            clr_table_q     <= '0;
            clr_addr_q      <= '0;
`endif
        end else begin
            rd_dat_q <= rd_dat_d;
`ifdef NX_ROREG_CLR_ON_READ_EN
            clr_vld_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (cmd_wr_w) begin
                        if (cmnd_op == OP_NOP) begin
                            stat_code_q <= SC_OK;
                        end else if (cmnd_op != OP_READ) begin
                            stat_code_q <= SC_BAD_OP;
                        end else if (tbl_bad_w) begin
                            stat_code_q <= SC_BAD_TABLE;
                        end else if (addr_bad_w) begin
                            stat_code_q <= SC_BAD_ADDR;
                        end else begin
                            stat_code_q     <= SC_BUSY;
                            stat_addr_q     <= cmnd_addr;
                            stat_table_id_q <= cmnd_table_id;
                            state_q         <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    // Commands arriving in this cycle are dropped without status change.
                    hold_q      <= HW'(entry_w[sel_idx_w]);
                    stat_code_q <= SC_OK;
                    state_q     <= ST_IDLE;
`ifdef NX_ROREG_CLR_ON_READ_EN
                    clr_vld_q   <= 1'b1;
                    clr_table_q <= stat_table_id_q;
                    clr_addr_q  <= stat_addr_q;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_dat          = rd_dat_q;
    assign stat_code       = stat_code_q;
    assign stat_datawords  = 5'(NW);
    assign stat_addr       = stat_addr_q;
    assign stat_table_id   = stat_table_id_q;
    assign capability_type = 4'h0;

`ifdef NX_ROREG_CLR_ON_READ_EN
    assign capability_lst  = 16'h0007;
    assign clr_vld         = clr_vld_q;
    assign clr_table       = clr_table_q;
    assign clr_addr        = clr_addr_q;
`else
    assign capability_lst  = 16'h0003;
    assign clr_vld         = 1'b0;
    assign clr_table       = '0;
    assign clr_addr        = '0;
`endif

endmodule

// File: tb/tb_nx_roreg_indirect_access_mt.sv
// Scoreboard bench for nx_roreg_indirect_access_mt (6 tables x 40 entries x 96 bits,
// so table and entry range errors are reachable). Honours NX_ROREG_CLR_ON_READ_EN.
module tb_nx_roreg_indirect_access_mt;

    localparam int NT = 6;
    localparam int NE = 40;
    localparam int DB = 96;
    localparam logic [10:0] STAT_A = 11'h400;
    localparam logic [10:0] CMND_A = 11'h40C;
    localparam logic [10:0] DATA_A = 11'h410;
`ifdef NX_ROREG_CLR_ON_READ_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  wr_stb = 1'b0;
    logic [10:0]           addr = '0;
    logic [3:0]            cmnd_op = '0;
    logic [5:0]            cmnd_addr = '0;
    logic [2:0]            cmnd_table_id = '0;
    logic [NT*NE*DB-1:0]   mem_a;
    logic [31:0]           rd_dat;
    logic [2:0]            stat_code;
    logic [4:0]            stat_datawords;
    logic [5:0]            stat_addr;
    logic [2:0]            stat_table_id;
    logic [15:0]           capability_lst;
    logic [3:0]            capability_type;
    logic                  clr_vld;
    logic [2:0]            clr_table;
    logic [5:0]            clr_addr;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];
    logic [95:0] model_hold = '0;
    logic [31:0] got, exp;

    nx_roreg_indirect_access_mt #(.N_ENTRIES(NE), .N_TABLES(NT)) dut (
        .clk(clk), .rst(rst), .wr_stb(wr_stb), .addr(addr), .cmnd_op(cmnd_op),
        .cmnd_addr(cmnd_addr), .cmnd_table_id(cmnd_table_id), .mem_a(mem_a),
        .rd_dat(rd_dat), .stat_code(stat_code), .stat_datawords(stat_datawords),
        .stat_addr(stat_addr), .stat_table_id(stat_table_id),
        .capability_lst(capability_lst), .capability_type(capability_type),
        .clr_vld(clr_vld), .clr_table(clr_table), .clr_addr(clr_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] stat_word(input logic [2:0] code, input logic [2:0] t,
                                              input logic [5:0] a);
        return {code, 5'd3, 4'(t), 4'b0, 16'(a)};
    endfunction

    function automatic logic [31:0] word_of(input logic [95:0] h, input int k);
        return (k < 3) ? h[32*k +: 32] : 32'h0;
    endfunction

    function automatic logic [95:0] get_entry(input int t, input int e);
        return mem_a[(t*NE+e)*DB +: DB];
    endfunction

    task automatic set_entry(input int t, input int e, input logic [95:0] v);
        mem_a[(t*NE+e)*DB +: DB] = v;
    endtask

    task automatic issue_cmd(input logic [3:0] op, input logic [2:0] t, input logic [5:0] a);
        @(negedge clk);
        wr_stb = 1'b1; addr = CMND_A; cmnd_op = op; cmnd_table_id = t; cmnd_addr = a;
        @(posedge clk); #1;
        wr_stb = 1'b0;
    endtask

    task automatic push_read(input logic [10:0] a, input logic [31:0] e);
        @(negedge clk);
        addr = a;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++; if (stat_code !== 3'd0) begin err_cnt++; $display("FAIL reset_stat_code got=%0d exp=0", stat_code); end
        vec_cnt++; if (rd_dat !== 32'h0) begin err_cnt++; $display("FAIL reset_rd_dat got=%h exp=0", rd_dat); end
        vec_cnt++; if ({stat_addr, stat_table_id, clr_vld} !== 10'h0) begin err_cnt++; $display("FAIL reset_stat_fields got=%h exp=0", {stat_addr, stat_table_id, clr_vld}); end
        vec_cnt++; if (stat_datawords !== 5'd3) begin err_cnt++; $display("FAIL datawords got=%0d exp=3", stat_datawords); end
        vec_cnt++; if (capability_lst !== (CLR_EN ? 16'h0007 : 16'h0003)) begin err_cnt++; $display("FAIL capability_lst got=%h exp=%h", capability_lst, CLR_EN ? 16'h0007 : 16'h0003); end
        vec_cnt++; if (capability_type !== 4'h0) begin err_cnt++; $display("FAIL capability_type got=%h exp=0", capability_type); end
        @(negedge clk); rst = 1'b0;
        push_read(STAT_A, stat_word(3'd0, 3'd0, 6'd0));
        got = rd_dat; exp = exp_q.pop_front();
        vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL reset_stat_read got=%h exp=%h", got, exp); end
        push_read(DATA_A, 32'h0);
        got = rd_dat; exp = exp_q.pop_front();
        vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL reset_hold_read got=%h exp=%h", got, exp); end
    endtask

    task automatic test_read();
        set_entry(2, 5, 96'h0000000A_0000000B_0000000C);
        model_hold = get_entry(2, 5);
        issue_cmd(4'd1, 3'd2, 6'd5);
        vec_cnt++; if (stat_code !== 3'd1) begin err_cnt++; $display("FAIL read_busy got=%0d exp=1", stat_code); end
        vec_cnt++; if ({stat_table_id, stat_addr} !== {3'd2, 6'd5}) begin err_cnt++; $display("FAIL read_latch got=%h exp=%h", {stat_table_id, stat_addr}, {3'd2, 6'd5}); end
        vec_cnt++; if (clr_vld !== 1'b0) begin err_cnt++; $display("FAIL read_clr_early got=%b exp=0", clr_vld); end
        @(posedge clk); #1;
        vec_cnt++; if (stat_code !== 3'd0) begin err_cnt++; $display("FAIL read_ok got=%0d exp=0", stat_code); end
        vec_cnt++; if (clr_vld !== CLR_EN) begin err_cnt++; $display("FAIL read_clr_vld got=%b exp=%b", clr_vld, CLR_EN); end
        // Source changes after capture must not reach the hold register.
        set_entry(2, 5, 96'hDEAD_BEEF_0123_4567_89AB_CDEF);
        for (int k = 0; k < 4; k++) begin
            push_read(DATA_A + 11'(k), word_of(model_hold, k));
            got = rd_dat; exp = exp_q.pop_front();
            vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL read_data w%0d got=%h exp=%h", k, got, exp); end
        end
        vec_cnt++; if (clr_vld !== 1'b0) begin err_cnt++; $display("FAIL read_clr_late got=%b exp=0", clr_vld); end
        push_read(STAT_A, stat_word(3'd0, 3'd2, 6'd5));
        got = rd_dat; exp = exp_q.pop_front();
        vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL read_stat_word got=%h exp=%h", got, exp); end
        push_read(11'h40F, 32'h0);
        got = rd_dat; exp = exp_q.pop_front();
        vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL read_unmapped got=%h exp=%h", got, exp); end
    endtask

    task automatic test_errors();
        logic [2:0] codes [4] = '{3'd3, 3'd5, 3'd4, 3'd0};
        logic [3:0] ops   [4] = '{4'd7, 4'd1, 4'd1, 4'd0};
        logic [2:0] tids  [4] = '{3'd7, 3'd6, 3'd0, 3'd0};
        logic [5:0] ents  [4] = '{6'd40, 6'd5, 6'd40, 6'd0};
        for (int i = 0; i < 4; i++) begin
            issue_cmd(ops[i], tids[i], ents[i]);
            @(posedge clk); #1;
            vec_cnt++; if (stat_code !== codes[i]) begin err_cnt++; $display("FAIL err_code%0d got=%0d exp=%0d", i, stat_code, codes[i]); end
            vec_cnt++; if ({stat_table_id, stat_addr} !== {3'd2, 6'd5}) begin err_cnt++; $display("FAIL err_latch%0d got=%h exp=%h", i, {stat_table_id, stat_addr}, {3'd2, 6'd5}); end
            push_read(DATA_A, word_of(model_hold, 0));
            got = rd_dat; exp = exp_q.pop_front();
            vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL err_hold%0d got=%h exp=%h", i, got, exp); end
        end
        // Highest valid table and entry are accepted.
        set_entry(5, 39, 96'h1111_2222_3333_4444_5555_6666);
        model_hold = get_entry(5, 39);
        issue_cmd(4'd1, 3'd5, 6'd39);
        vec_cnt++; if (stat_code !== 3'd1) begin err_cnt++; $display("FAIL edge_busy got=%0d exp=1", stat_code); end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            push_read(DATA_A + 11'(k), word_of(model_hold, k));
            got = rd_dat; exp = exp_q.pop_front();
            vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL edge_data w%0d got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        model_hold = get_entry(3, 7);
        issue_cmd(4'd1, 3'd3, 6'd7);
        issue_cmd(4'd1, 3'd1, 6'd2);
        vec_cnt++; if (stat_code !== 3'd0) begin err_cnt++; $display("FAIL b2b_code got=%0d exp=0", stat_code); end
        vec_cnt++; if ({stat_table_id, stat_addr} !== {3'd3, 6'd7}) begin err_cnt++; $display("FAIL b2b_latch got=%h exp=%h", {stat_table_id, stat_addr}, {3'd3, 6'd7}); end
        for (int k = 0; k < 3; k++) begin
            push_read(DATA_A + 11'(k), word_of(model_hold, k));
            got = rd_dat; exp = exp_q.pop_front();
            vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL b2b_data w%0d got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_reset_mid_capture();
        bit clr_seen = 1'b0;
        issue_cmd(4'd1, 3'd4, 6'd9);
        rst = 1'b1;
        #2;
        vec_cnt++; if ({stat_code, stat_table_id, stat_addr, clr_vld} !== 13'h0) begin err_cnt++; $display("FAIL midrst_fields got=%h exp=0", {stat_code, stat_table_id, stat_addr, clr_vld}); end
        vec_cnt++; if (rd_dat !== 32'h0) begin err_cnt++; $display("FAIL midrst_rd_dat got=%h exp=0", rd_dat); end
        @(posedge clk); #1;
        if (clr_vld) clr_seen = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_hold = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (clr_vld) clr_seen = 1'b1;
        end
        vec_cnt++; if (clr_seen !== 1'b0) begin err_cnt++; $display("FAIL midrst_clr got=%b exp=0", clr_seen); end
        push_read(DATA_A, word_of(model_hold, 0));
        got = rd_dat; exp = exp_q.pop_front();
        vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL midrst_hold got=%h exp=%h", got, exp); end
        model_hold = get_entry(4, 9);
        issue_cmd(4'd1, 3'd4, 6'd9);
        @(posedge clk); #1;
        vec_cnt++; if (stat_code !== 3'd0) begin err_cnt++; $display("FAIL midrst_next_code got=%0d exp=0", stat_code); end
        push_read(DATA_A + 11'd2, word_of(model_hold, 2));
        got = rd_dat; exp = exp_q.pop_front();
        vec_cnt++; if (got !== exp) begin err_cnt++; $display("FAIL midrst_next_data got=%h exp=%h", got, exp); end
    endtask

    task automatic test_clr();
        issue_cmd(4'd1, 3'd1, 6'd31);
        vec_cnt++; if (clr_vld !== 1'b0) begin err_cnt++; $display("FAIL clr_t1 got=%b exp=0", clr_vld); end
        @(posedge clk); #1;
        vec_cnt++; if ({clr_vld, clr_table, clr_addr} !== (CLR_EN ? {1'b1, 3'd1, 6'd31} : 10'h0)) begin
            err_cnt++; $display("FAIL clr_t2 got=%h exp=%h", {clr_vld, clr_table, clr_addr}, CLR_EN ? {1'b1, 3'd1, 6'd31} : 10'h0);
        end
        @(posedge clk); #1;
        vec_cnt++; if (clr_vld !== 1'b0) begin err_cnt++; $display("FAIL clr_t3 got=%b exp=0", clr_vld); end
    endtask

    initial begin
        for (int i = 0; i < NT*NE*DB/32; i++) mem_a[32*i +: 32] = $urandom;
        test_reset();
        test_read();
        test_errors();
        test_back_to_back();
        test_reset_mid_capture();
        test_clr();
        if (exp_q.size() != 0) begin
            err_cnt++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
